// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction cache and its line store.
package icache_pkg;

  typedef logic [31:0] ADDR_TYPE;
  typedef logic [31:0] INST_TYPE;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam ADDR_TYPE ADDR_RESET = 32'h0000_0000;
  localparam INST_TYPE INST_RESET = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } ICACHE_STATE_TYPE;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the direct-mapped instruction cache.
// Combinational lookup, synchronous fill; reset clears only the valid bits.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [INDEX_BITS-1:0]   rd_index,
  input  logic [29-INDEX_BITS:0]  rd_tag,
  output logic                    rd_hit,
  output logic [31:0]             rd_data,
  input  logic                    wr_en,
  input  logic [INDEX_BITS-1:0]   wr_index,
  input  logic [29-INDEX_BITS:0]  wr_tag,
  input  logic [31:0]             wr_data
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  INST_TYPE            data [LINES];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid <= '0;
    end else if (rdy_in && wr_en) begin
      valid[wr_index] <= TRUE;
    end
  end

  // Tag and data need no reset: they are meaningless while valid is clear.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  assign rd_hit  = valid[rd_index] && (tags[rd_index] == rd_tag);
  assign rd_data = data[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: one-cycle hits, single-word fills from the
// memory controller fetch port on a miss, with flush-tolerant response discard.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        req_from_fetcher,
  input  logic [31:0] pc_from_fetcher,
  input  logic        clear_from_rob,
  output logic        done_to_fetcher,
  output logic [31:0] inst_to_fetcher,
  output logic        busy_to_fetcher,
  output logic        enable_to_mem,
  output logic [31:0] address_to_mem,
  input  logic        end_from_mem,
  input  logic [31:0] inst_from_mem
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  // Memory handshake: enable_to_mem/address_to_mem are held as a level from
  // the miss until the cycle end_from_mem pulses; inst_from_mem is valid only
  // in that cycle. done_to_fetcher is a one-cycle pulse qualifying inst.
  ICACHE_STATE_TYPE state, state_next;
  logic             enable_next;
  ADDR_TYPE         address_next;
  logic             done_next;
  INST_TYPE         inst_next;
  logic             discard, discard_next;
  logic             fill;

  ADDR_TYPE            pc_aligned;
  logic                hit;
  INST_TYPE            hit_data;

  assign pc_aligned = pc_from_fetcher & 32'hFFFF_FFFC;

  icache_line_store #(
    .INDEX_BITS(INDEX_BITS)
  ) u_line_store (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .rd_index (pc_aligned[INDEX_BITS+1:2]),
    .rd_tag   (pc_aligned[31:INDEX_BITS+2]),
    .rd_hit   (hit),
    .rd_data  (hit_data),
    .wr_en    (fill),
    .wr_index (address_to_mem[INDEX_BITS+1:2]),
    .wr_tag   (address_to_mem[31:31-TAG_BITS+1]),
    .wr_data  (inst_from_mem)
  );

  always_comb begin
    state_next   = state;
    enable_next  = enable_to_mem;
    address_next = address_to_mem;
    done_next    = FALSE;
    inst_next    = inst_to_fetcher;
    discard_next = discard;
    fill         = FALSE;
    case (state)
      IDLE: begin
        if (req_from_fetcher && !clear_from_rob) begin
          if (hit) begin
            done_next = TRUE;
            inst_next = hit_data;
          end else begin
            enable_next  = TRUE;
            address_next = pc_aligned;
            state_next   = MISS;
          end
        end
      end
      MISS: begin
        if (end_from_mem) begin
          // The fill is kept even when discarded: the word is still correct.
          fill         = TRUE;
          enable_next  = FALSE;
          discard_next = FALSE;
          state_next   = IDLE;
          if (!discard && !clear_from_rob) begin
            done_next = TRUE;
            inst_next = inst_from_mem;
          end
        end else if (clear_from_rob) begin
          discard_next = TRUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      enable_to_mem   <= FALSE;
      address_to_mem  <= ADDR_RESET;
      done_to_fetcher <= FALSE;
      inst_to_fetcher <= INST_RESET;
      discard         <= FALSE;
    end else if (rdy_in) begin
      state           <= state_next;
      enable_to_mem   <= enable_next;
      address_to_mem  <= address_next;
      done_to_fetcher <= done_next;
      inst_to_fetcher <= inst_next;
      discard         <= discard_next;
    end
  end

  assign busy_to_fetcher = (state != IDLE);

endmodule
